// File: rtl/unidad_busqueda.sv
// ---------------------------------------------------------------------------
// unidad_busqueda -- instruction-fetch stage feeding the control unit.
//
// Holds the fetch PC, requests words from instruction memory over a
// req/ack handshake and registers each fetched word into the IF/ID register.
// A one-entry skid buffer catches a word that returns while the stage is
// stalled. Taken branches and jumps redirect the PC and flush IF/ID.
//
// Parameters:
//   ADDR_W   PC / instruction-memory address width (must be > 28)
//   RESET_PC PC loaded on reset
//   INSTR_W  instruction word width (must be >= 32)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem_req/addr   fetch request and address (addr == pc while req)
//   imem_ack/data   memory response, data valid when ack=1
//   stall           freeze live IF/ID contents
//   branch_taken    BEQ taken for the instruction in IF/ID
//   jump            J decoded for the instruction in IF/ID
//   instr, op_code  IF/ID instruction and its opcode field
//   id_pc4          PC+4 of the IF/ID instruction
//   id_valid        IF/ID holds a live instruction
//   pc              current fetch PC
//
// Optional build macro FETCH_CNT_EN adds fetch_count[31:0] (words written
// into IF/ID) and flush_count[15:0] (accepted redirects).
// ---------------------------------------------------------------------------
module unidad_busqueda #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                INSTR_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic               jump,
   output logic [INSTR_W-1:0] instr,
   output logic [5:0]         op_code,
   output logic [ADDR_W-1:0]  id_pc4,
   output logic               id_valid,
   output logic [ADDR_W-1:0]  pc
`ifdef FETCH_CNT_EN
   ,
   output logic [31:0]        fetch_count,
   output logic [15:0]        flush_count
`endif
);

   typedef enum logic [1:0] {
      S_REQ,   // issue request for pc
      S_WAIT,  // request open, waiting for ack
      S_HOLD,  // word parked in skid buffer while stalled
      S_DROP   // outstanding ack belongs to a flushed path
   } state_t;

   state_t             r_state, w_state_next;
   logic [ADDR_W-1:0]  r_pc, w_pc_next;
   logic [INSTR_W-1:0] r_instr, w_instr_next;
   logic [ADDR_W-1:0]  r_id_pc4, w_id_pc4_next;
   logic               r_id_valid, w_id_valid_next;
   logic [INSTR_W-1:0] r_skid, w_skid_next;
   logic [ADDR_W-1:0]  r_skid_pc4, w_skid_pc4_next;

   logic               w_redirect;
   logic               w_load_ifid;
   logic [ADDR_W-1:0]  w_pc4;
   logic [ADDR_W-1:0]  w_jump_target;
   logic [ADDR_W-1:0]  w_branch_target;
   logic [ADDR_W-1:0]  w_target;

   // Redirect decisions only come from live IF/ID contents.
   assign w_redirect      = r_id_valid & (jump | branch_taken);
   assign w_pc4           = r_pc + ADDR_W'(4);
   assign w_jump_target   = {r_id_pc4[ADDR_W-1:28], r_instr[25:0], 2'b00};
   assign w_branch_target = r_id_pc4 +
                            {{(ADDR_W-18){r_instr[15]}}, r_instr[15:0], 2'b00};
   // Jump wins when both are asserted.
   assign w_target        = jump ? w_jump_target : w_branch_target;

   always_comb begin
      w_state_next    = r_state;
      w_pc_next       = r_pc;
      w_instr_next    = r_instr;
      w_id_pc4_next   = r_id_pc4;
      w_id_valid_next = r_id_valid;
      w_skid_next     = r_skid;
      w_skid_pc4_next = r_skid_pc4;
      w_load_ifid     = 1'b0;

      if (w_redirect) begin
         // Flush beats stall. Leaving S_HOLD implicitly discards the skid.
         w_pc_next       = w_target;
         w_id_valid_next = 1'b0;
         if (r_state == S_WAIT && !imem_ack)
            w_state_next = S_DROP;
         else
            w_state_next = S_REQ;
      end else begin
         case (r_state)
            S_REQ: begin
               w_state_next = S_WAIT;
            end
            S_WAIT: begin
               if (imem_ack) begin
                  w_pc_next = w_pc4;
                  if (!stall) begin
                     w_instr_next    = imem_data;
                     w_id_pc4_next   = w_pc4;
                     w_id_valid_next = 1'b1;
                     w_load_ifid     = 1'b1;
                     w_state_next    = S_REQ;
                  end else begin
                     w_skid_next     = imem_data;
                     w_skid_pc4_next = w_pc4;
                     w_state_next    = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  w_instr_next    = r_skid;
                  w_id_pc4_next   = r_skid_pc4;
                  w_id_valid_next = 1'b1;
                  w_load_ifid     = 1'b1;
                  w_state_next    = S_REQ;
               end
            end
            S_DROP: begin
               if (imem_ack)
                  w_state_next = S_REQ;
            end
            default: begin
               w_state_next = S_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_REQ;
         r_pc       <= RESET_PC;
         r_instr    <= '0;
         r_id_pc4   <= '0;
         r_id_valid <= 1'b0;
         r_skid     <= '0;
         r_skid_pc4 <= '0;
      end else begin
         r_state    <= w_state_next;
         r_pc       <= w_pc_next;
         r_instr    <= w_instr_next;
         r_id_pc4   <= w_id_pc4_next;
         r_id_valid <= w_id_valid_next;
         r_skid     <= w_skid_next;
         r_skid_pc4 <= w_skid_pc4_next;
      end
   end

`ifdef FETCH_CNT_EN
   logic [31:0] r_fetch_count;
   logic [15:0] r_flush_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (w_load_ifid)
            r_fetch_count <= r_fetch_count + 32'd1;
         if (w_redirect)
            r_flush_count <= r_flush_count + 16'd1;
      end
   end

   assign fetch_count = r_fetch_count;
   assign flush_count = r_flush_count;
`endif

   // rst gates the request combinationally so nothing is issued during reset.
   assign imem_req  = !rst && (r_state == S_REQ || r_state == S_WAIT);
   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign instr     = r_instr;
   assign op_code   = r_instr[31:26];
   assign id_pc4    = r_id_pc4;
   assign id_valid  = r_id_valid;

endmodule

// File: tb/tb_unidad_busqueda.sv
// ---------------------------------------------------------------------------
// tb_unidad_busqueda -- directed scenarios followed by a randomized run.
// A cycle-level reference model tracks PC, IF/ID, skid contents and whether
// a memory request is being issued, awaited or discarded; the bench's
// memory only acknowledges while the model says a request is open.
// ---------------------------------------------------------------------------
module tb_unidad_busqueda;

   logic        clk = 1'b0;
   logic        rst, imem_req, imem_ack, stall, branch_taken, jump, id_valid;
   logic [31:0] imem_addr, imem_data, instr, id_pc4, pc;
   logic [5:0]  op_code;
`ifdef FETCH_CNT_EN
   logic [31:0] fetch_count;
   logic [15:0] flush_count;
`endif

   always #5 clk = ~clk;

   unidad_busqueda #(.ADDR_W(32), .RESET_PC(32'h0), .INSTR_W(32)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data),
      .stall(stall), .branch_taken(branch_taken), .jump(jump),
      .instr(instr), .op_code(op_code), .id_pc4(id_pc4),
      .id_valid(id_valid), .pc(pc)
`ifdef FETCH_CNT_EN
      , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
   );

   int vectors    = 0;
   int miscompares = 0;

   // reference model
   logic [31:0] m_pc, m_instr, m_pc4, m_skid_instr, m_skid_pc4;
   bit          m_valid, m_skid_full, m_issuing, m_waiting, m_discard, m_known;
   int unsigned m_fetches, m_flushes;
   int          lat_cnt, lat_cfg;
   bit          rand_lat, rand_data;
   logic [31:0] mem_ovr [logic [31:0]];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_ovr.exists(a)) return mem_ovr[a];
      return a;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, clock,
   // then advance the model with the same inputs.
   task automatic tick(input bit r, input bit s, input bit j, input bit b);
      bit          ack, exp_req;
      logic [31:0] d, tgt;
      rst = r; stall = s; jump = j; branch_taken = b;
      ack = !r && (m_waiting || m_discard) && (lat_cnt == 0);
      if (m_discard) d = 32'hDEAD_BEEF;
      else if (rand_data) d = $urandom;
      else d = mem_word(m_pc);
      imem_ack  = ack;
      imem_data = ack ? d : $urandom;
      #1;
      exp_req = !r && (m_issuing || m_waiting);
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      if (m_known) begin
         chk("pc", pc, m_pc);
         chk("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
         chk("instr", instr, m_instr);
         chk("id_pc4", id_pc4, m_pc4);
         chk("op_code", {26'b0, op_code}, {26'b0, m_instr[31:26]});
`ifdef FETCH_CNT_EN
         chk("fetch_count", fetch_count, m_fetches);
         chk("flush_count", {16'b0, flush_count}, {16'b0, m_flushes[15:0]});
`endif
      end
      @(posedge clk);
      if (r) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
         m_skid_full = 0; m_issuing = 1; m_waiting = 0; m_discard = 0;
         m_known = 1; m_fetches = 0; m_flushes = 0;
      end else if (m_valid && (j || b)) begin
         if (j) tgt = {m_pc4[31:28], m_instr[25:0], 2'b00};
         else   tgt = m_pc4 + 32'($signed(m_instr[15:0])) * 4;
         m_flushes++;
         m_discard   = m_waiting && !ack;
         if (m_discard) lat_cnt--;
         m_issuing   = !m_discard;
         m_waiting   = 0;
         m_skid_full = 0;
         m_valid     = 0;
         m_pc        = tgt;
      end else if (m_issuing) begin
         m_issuing = 0;
         m_waiting = 1;
         lat_cnt   = rand_lat ? int'($urandom_range(3, 0)) : lat_cfg;
      end else if (m_waiting) begin
         if (ack) begin
            m_waiting = 0;
            if (!s) begin
               m_instr = d; m_pc4 = m_pc + 4; m_valid = 1;
               m_issuing = 1; m_fetches++;
            end else begin
               m_skid_instr = d; m_skid_pc4 = m_pc + 4; m_skid_full = 1;
            end
            m_pc = m_pc + 4;
         end else lat_cnt--;
      end else if (m_skid_full) begin
         if (!s) begin
            m_instr = m_skid_instr; m_pc4 = m_skid_pc4; m_valid = 1;
            m_skid_full = 0; m_issuing = 1; m_fetches++;
         end
      end else if (m_discard) begin
         if (ack) begin m_discard = 0; m_issuing = 1; end
         else lat_cnt--;
      end
      #1;
      $display("cycle rst=%0b stall=%0b jump=%0b br=%0b ack=%0b -> pc=%h instr=%h valid=%0b",
               r, s, j, b, ack, pc, instr, id_valid);
   endtask

   task automatic do_reset();
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
   endtask

   initial begin
      rst = 1; stall = 0; jump = 0; branch_taken = 0; imem_ack = 0; imem_data = 0;
      m_known = 0; m_issuing = 0; m_waiting = 0; m_discard = 0; m_valid = 0;
      m_skid_full = 0; m_pc = 0; m_instr = 0; m_pc4 = 0; m_fetches = 0; m_flushes = 0;
      m_skid_instr = 0; m_skid_pc4 = 0;
      lat_cnt = 0; lat_cfg = 0; rand_lat = 0; rand_data = 0;
      @(posedge clk); #1;

      // Free run with data = address, then a 5-cycle stall over an ack.
      do_reset();
      chk("rst_valid", {31'b0, id_valid}, 32'h0);
      chk("rst_pc", pc, 32'h0);
      tick(0, 0, 0, 0); tick(0, 0, 0, 0);
      chk("t1_word0", instr, 32'h0);
      chk("t1_valid", {31'b0, id_valid}, 32'h1);
      tick(0, 0, 0, 0); tick(0, 0, 0, 0);
      chk("t1_word1", instr, 32'h4);
      tick(0, 0, 0, 0);                 // request for 0x8 issued
      tick(0, 1, 0, 0);                 // ack for 0x8 arrives under stall
      chk("t2_req_hold", {31'b0, imem_req}, 32'h0);
      chk("t2_instr_hold", instr, 32'h4);
      repeat (4) tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);                 // release: skid word moves to IF/ID
      chk("t2_skid_word", instr, 32'h8);
      chk("t2_next_addr", imem_addr, 32'hC);
      tick(0, 0, 0, 0); tick(0, 0, 0, 0);

      // Taken branch: 0x8 + (3 << 2) = 0x14.
      mem_ovr.delete(); mem_ovr[32'h4] = 32'h1000_0003;
      do_reset();
      repeat (4) tick(0, 0, 0, 0);
      chk("t3_instr", instr, 32'h1000_0003);
      chk("t3_pc4", id_pc4, 32'h8);
      tick(0, 0, 0, 1);
      chk("t3_pc", pc, 32'h14);
      chk("t3_flush", {31'b0, id_valid}, 32'h0);
      chk("t3_addr", imem_addr, 32'h14);
      repeat (3) tick(0, 0, 0, 0);

      // Jump and branch together: jump wins, target 0x40 << 2 = 0x100.
      mem_ovr.delete(); mem_ovr[32'h4] = 32'h0800_0040;
      do_reset();
      repeat (4) tick(0, 0, 0, 0);
      tick(0, 0, 1, 1);
      chk("t4_pc", pc, 32'h100);
      chk("t4_flush", {31'b0, id_valid}, 32'h0);
      repeat (3) tick(0, 0, 0, 0);

      // Redirect while waiting on a 3-cycle ack: stale word must be dropped.
      lat_cfg = 2;
      do_reset();
      repeat (9) tick(0, 0, 0, 0);
      chk("t5_jump_live", instr, 32'h0800_0040);
      tick(0, 0, 1, 0);
      chk("t5_drop_req", {31'b0, imem_req}, 32'h0);
      tick(0, 0, 0, 0); tick(0, 0, 0, 0);
      chk("t5_target_addr", imem_addr, 32'h100);
      chk("t5_target_req", {31'b0, imem_req}, 32'h1);
      repeat (6) tick(0, 0, 0, 0);

      // PC wrap: branch 0x8 + (-3 << 2) = 0xFFFFFFFC, then fetch wraps to 0.
      lat_cfg = 0;
      mem_ovr.delete(); mem_ovr[32'h4] = 32'h1000_FFFD;
      do_reset();
      repeat (4) tick(0, 0, 0, 0);
      tick(0, 0, 0, 1);
      chk("t6_pc", pc, 32'hFFFF_FFFC);
      tick(0, 0, 0, 0); tick(0, 0, 0, 0);
      chk("t6_pc4", id_pc4, 32'h0);
      chk("t6_next_addr", imem_addr, 32'h0);

      // Randomized run against the model.
      mem_ovr.delete();
      rand_lat = 1; rand_data = 1;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         tick($urandom_range(99, 0) == 0, $urandom_range(9, 0) < 3,
              $urandom_range(9, 0) == 0, $urandom_range(9, 0) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
